serial_tx: RTL
==============

SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the parallel word width in bits (legal values 1..16).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 4, meaning the CLK cycles per serial bit period (legal values 1..65535).
REQ-003 SHALL have port CLK  input  1  system clock, with all state updating on the rising edge.
REQ-004 SHALL have port RESET  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port DIN  input  DATA_W  parallel word to transmit.
REQ-006 SHALL have port DIN_VALID  input  1  source asserts that DIN holds a word.
REQ-007 SHALL have port DIN_READY  output  1  block can accept a word this cycle.
REQ-008 SHALL have port TXD  output  1  serial line, which idles high.
REQ-009 SHALL have port BUSY  output  1  a frame is in progress.

Function
REQ-010 SHALL implement a state machine with states IDLE, START, DATA, PARITY and STOP; PARITY exists only per REQ-024.
REQ-011 SHALL drive DIN_READY=1 only in IDLE; it is a registered-state decode with no combinational path from DIN_VALID.
REQ-012 SHALL accept a word on the rising edge where DIN_VALID=1 and DIN_READY=1, latching DIN into an internal shift register and moving to START.
REQ-013 SHALL ignore DIN and DIN_VALID in every state other than IDLE; changes to DIN after acceptance SHALL NOT affect the frame in flight.
REQ-014 SHALL drive TXD=1 in IDLE, TXD=0 in START, TXD=the current data bit in DATA, and TXD=1 in STOP.
REQ-015 SHALL transmit the data bits LSB first.
REQ-016 SHALL hold each state's TXD level for exactly CLKS_PER_BIT cycles, timed by a bit-period counter that reloads on every state or bit change.
REQ-017 SHALL stay in DATA for exactly DATA_W bit periods, tracked by a bit index that counts 0..DATA_W-1 and then leaves DATA.
REQ-018 SHALL return from STOP to IDLE, so DIN_READY rises in the first cycle after the stop period ends.
REQ-019 SHALL NOT accept back-to-back words before IDLE; with DIN_VALID held high, the next word SHALL be accepted at the edge ending the first IDLE cycle, giving exactly one cycle of TXD=1 between the stop period and the next start bit.
REQ-020 SHALL drive BUSY = NOT DIN_READY in every cycle.
REQ-021 SHALL work with CLKS_PER_BIT=1, with one cycle per bit and no zero-length states.
REQ-022 SHALL register TXD so that TXD never glitches at state transitions.

Reset
REQ-023 SHALL, while RESET=1 and independent of CLK, force state=IDLE, TXD=1, DIN_READY=1, BUSY=0, all counters to 0 and the shift register to 0; a frame cut by reset mid-flight SHALL be aborted and SHALL NOT be resumed.

Configuration
REQ-024 SHALL, when macro SERIAL_TX_PARITY_EN is defined, insert one PARITY bit period between DATA and STOP with TXD = even parity (XOR of all DATA_W data bits), giving frame length (DATA_W+3)*CLKS_PER_BIT.
REQ-025 SHALL, when SERIAL_TX_PARITY_EN is undefined, contain no PARITY state or parity logic, giving frame length (DATA_W+2)*CLKS_PER_BIT.

Verification
REQ-026 SHALL cover single frame: DATA_W=8, CLKS_PER_BIT=4, no parity, DIN=0xA5 accepted -> TXD=0,1,0,1,0,0,1,0,1,1, each level held 4 cycles; BUSY=1 for 40 cycles.
REQ-027 SHALL cover parity: SERIAL_TX_PARITY_EN defined, DIN=0xA5 -> parity bit 0; DIN=0x07 -> parity bit 1; BUSY=1 for 44 cycles.
REQ-028 SHALL cover back-to-back: DIN_VALID held 1 with 0x01 then 0x80 -> two frames separated by exactly 1 idle cycle of TXD=1; second frame data bits 0,0,0,0,0,0,0,1.
REQ-029 SHALL cover hold-off: DIN changed to 0xFF at cycle 5 of a 0x00 frame -> all 8 data bits transmit as 0 and DIN_READY stays 0.
REQ-030 SHALL cover reset mid-frame: RESET pulsed during data bit 3 -> TXD=1 and DIN_READY=1 immediately, with no remaining bits emitted after release.
REQ-031 SHALL cover minimum period: CLKS_PER_BIT=1, DIN=0x3C -> 10-cycle frame 0,0,0,1,1,1,1,0,0,1.

Source files
------------

// File: rtl/serial_tx.sv
// serial_tx: parallel-in, LSB-first serial transmitter with registered TXD.
// Optional even parity bit enabled by defining SERIAL_TX_PARITY_EN.
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] DIN,
  input  logic              DIN_VALID,
  output logic              DIN_READY,
  output logic              TXD,
  output logic              BUSY
);

  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [15:0]   LAST_CNT = 16'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef SERIAL_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t            state, state_n;
  logic [15:0]       cnt, cnt_n;
  logic [IW-1:0]     idx, idx_n;
  logic [DATA_W-1:0] sh, sh_n, sh_shift;
  logic              txd_q, txd_n;
  logic              bit_end;

`ifdef SERIAL_TX_PARITY_EN
  logic par_q, par_n;
`endif

  assign sh_shift  = sh >> 1;
  assign bit_end   = (cnt == LAST_CNT);
  assign DIN_READY = (state == IDLE);
  assign BUSY      = ~DIN_READY;
  assign TXD       = txd_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      txd_q <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      sh    <= sh_n;
      txd_q <= txd_n;
`ifdef SERIAL_TX_PARITY_EN
      par_q <= par_n;
`endif
    end
  end

  // txd_n is the level of the state being entered, so TXD is glitch-free
  always_comb begin
    state_n = state;
    cnt_n   = bit_end ? '0 : cnt + 16'd1;
    idx_n   = idx;
    sh_n    = sh;
    txd_n   = txd_q;
`ifdef SERIAL_TX_PARITY_EN
    par_n   = par_q;
`endif
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        txd_n = 1'b1;
        if (DIN_VALID) begin
          state_n = START;
          sh_n    = DIN;
          txd_n   = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
          par_n   = ^DIN;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          idx_n   = '0;
          txd_n   = sh[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx == LAST_IDX) begin
            idx_n = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_n = PARITY;
            txd_n   = par_q;
`else
            state_n = STOP;
            txd_n   = 1'b1;
`endif
          end else begin
            idx_n = idx + 1'b1;
            sh_n  = sh_shift;
            txd_n = sh_shift[0];
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          txd_n   = 1'b1;
        end
      end
`endif
      STOP: begin
        txd_n = 1'b1;
        if (bit_end) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        txd_n   = 1'b1;
      end
    endcase
  end

endmodule
